// File: rtl/decod_morse.sv
// Morse digit receiver: times marks and spaces on a synchronised key line,
// rebuilds the 5-symbol pattern and emits the BCD digit or an error pulse.
module decod_morse #(
    parameter int CNT_W     = 8,
    parameter int DOT_MAX   = 2,
    parameter int GAP_TICKS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_in,
    output logic [3:0] digit,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        EVAL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_TICKS);

    state_t           state, state_n;
    logic             key_m, key_s;
    logic [4:0]       pattern, pattern_n;
    logic [2:0]       sym_cnt, sym_cnt_n;
    logic             ovf, ovf_n;
    logic             from_space, from_space_n;
    logic [CNT_W-1:0] mark_cnt, mark_cnt_n;
    logic [CNT_W-1:0] space_cnt, space_cnt_n;
    logic [CNT_W-1:0] mark_inc, space_inc;
    logic [3:0]       digit_n;
    logic             valid_n, error_n;
    logic             sym;
    logic             lut_hit;
    logic [3:0]       lut_digit;

    always_comb begin
        lut_hit   = 1'b1;
        lut_digit = 4'd0;
        case (pattern)
            5'b00000: lut_digit = 4'd0;
            5'b10000: lut_digit = 4'd1;
            5'b11000: lut_digit = 4'd2;
            5'b11100: lut_digit = 4'd3;
            5'b11110: lut_digit = 4'd4;
            5'b11111: lut_digit = 4'd5;
            5'b01111: lut_digit = 4'd6;
            5'b00111: lut_digit = 4'd7;
            5'b00011: lut_digit = 4'd8;
            5'b00001: lut_digit = 4'd9;
            default:  lut_hit   = 1'b0;
        endcase
    end

    // The clk that ends a mark or space still counts its tick, so an
    // N-clk mark measures N ticks when tick is held high.
    always_comb begin
        mark_inc  = (mark_cnt == CNT_MAX) ? mark_cnt : mark_cnt + CNT_W'(tick);
        space_inc = (space_cnt == CNT_MAX) ? space_cnt : space_cnt + CNT_W'(tick);
        sym       = (mark_inc <= DOT_LIM);
    end

    always_comb begin
        state_n      = state;
        pattern_n    = pattern;
        sym_cnt_n    = sym_cnt;
        ovf_n        = ovf;
        from_space_n = from_space;
        mark_cnt_n   = mark_cnt;
        space_cnt_n  = space_cnt;
        digit_n      = digit;
        valid_n      = 1'b0;
        error_n      = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_n      = MARK;
                    mark_cnt_n   = '0;
                    from_space_n = 1'b0;
                end
            end
            MARK: begin
                if (key_s) begin
                    mark_cnt_n = mark_inc;
                end else if (mark_inc == '0) begin
                    // tickless blip: resume where we were, space count untouched
                    state_n = from_space ? SPACE : IDLE;
                end else begin
                    if (sym_cnt < 3'd5) begin
                        pattern_n = {pattern[3:0], sym};
                        sym_cnt_n = sym_cnt + 3'd1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                    state_n     = SPACE;
                    space_cnt_n = '0;
                end
            end
            SPACE: begin
                space_cnt_n = space_inc;
                if (space_inc >= GAP_LIM) begin
                    state_n = EVAL;
                end else if (key_s) begin
                    state_n      = MARK;
                    mark_cnt_n   = '0;
                    from_space_n = 1'b1;
                end
            end
            EVAL: begin
                if (sym_cnt == 3'd5 && !ovf && lut_hit) begin
                    digit_n = lut_digit;
                    valid_n = 1'b1;
                end else begin
                    error_n = 1'b1;
                end
                pattern_n = '0;
                sym_cnt_n = '0;
                ovf_n     = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_m      <= 1'b0;
            key_s      <= 1'b0;
            state      <= IDLE;
            pattern    <= '0;
            sym_cnt    <= '0;
            ovf        <= 1'b0;
            from_space <= 1'b0;
            mark_cnt   <= '0;
            space_cnt  <= '0;
            digit      <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
        end else begin
            key_m      <= key_in;
            key_s      <= key_m;
            state      <= state_n;
            pattern    <= pattern_n;
            sym_cnt    <= sym_cnt_n;
            ovf        <= ovf_n;
            from_space <= from_space_n;
            mark_cnt   <= mark_cnt_n;
            space_cnt  <= space_cnt_n;
            digit      <= digit_n;
            valid      <= valid_n;
            error      <= error_n;
        end
    end

    always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_decod_morse.sv
// Scoreboard bench for decod_morse: characters are described as mark lengths,
// expected results come from the digit table and are checked on each pulse.
module tb_decod_morse;

    localparam int DOT_MAX = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_in;
    logic [3:0] digit;
    logic       valid;
    logic       error;
    logic       busy;

    always #5 clk = ~clk;

    decod_morse #(
        .CNT_W    (8),
        .DOT_MAX  (DOT_MAX),
        .GAP_TICKS(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .key_in(key_in),
        .digit (digit),
        .valid (valid),
        .error (error),
        .busy  (busy)
    );

    typedef struct {
        logic       is_err;
        logic [3:0] dig;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  last_digit = 4'd0;
    logic [2:0]  tpipe = '1;
    logic [4:0]  tbl[10] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
                             5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};

    // Expected outcome of a character given the ticks each mark lasted.
    function automatic exp_t expect_char(input int n, input int eff[8]);
        exp_t       e;
        logic [4:0] p;
        p        = '0;
        e.is_err = 1'b1;
        e.dig    = last_digit;
        if (n == 5) begin
            for (int i = 0; i < 5; i++) p = {p[3:0], (eff[i] <= DOT_MAX)};
            for (int d = 0; d < 10; d++)
                if (p == tbl[d]) begin
                    e.is_err = 1'b0;
                    e.dig    = 4'(d);
                end
        end
        if (!e.is_err) last_digit = e.dig;
        return e;
    endfunction

    // tick mask is aligned to key_in time; the DUT counts key_s three clk later
    task automatic cyc(input logic k, input logic m);
        @(posedge clk);
        #1;
        key_in = k;
        tick   = tpipe[2];
        tpipe  = {tpipe[1:0], m};
    endtask

    // space=0 picks a random inter-symbol space; skip drops one tick in the
    // first mark; glued means the first mark was pressed as the gap completed
    // and so loses the two clk spent in EVAL and IDLE.
    task automatic send_char(input int n, input int lens[8], input int space,
                             input int gap, input bit skip, input bit glued);
        int eff[8];
        int sp;
        eff = lens;
        if (skip) eff[0] = eff[0] - 1;
        if (glued) eff[0] = eff[0] - 2;
        sbq.push_back(expect_char(n, eff));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < lens[i]; j++) cyc(1'b1, !(skip && i == 0 && j == 1));
            if (i != n - 1) begin
                sp = (space != 0) ? space : int'($urandom_range(1, 5));
                for (int j = 0; j < sp; j++) cyc(1'b0, 1'b1);
            end
        end
        for (int j = 0; j < gap; j++) cyc(1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid || error) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b digit=%0d, required no pulse",
                         valid, error, digit);
            end else begin
                e = sbq.pop_front();
                if ((valid && error) || error != e.is_err || digit != e.dig) begin
                    n_fail++;
                    $display("FAIL char_result: valid=%0b error=%0b digit=%0d, required error=%0b digit=%0d",
                             valid, error, digit, e.is_err, e.dig);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lens[8];
        int n;
        int d;
        reset  = 1'b0;
        key_in = 1'b0;
        tick   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (digit !== 4'd0 || valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: digit=%0d valid=%0b error=%0b busy=%0b, required all 0",
                     digit, valid, error, busy);
        end
        reset = 1'b1;
        repeat (4) cyc(1'b0, 1'b1);

        send_char(5, '{2, 2, 5, 5, 5, 0, 0, 0}, 3, 8, 0, 0);    // 2
        send_char(5, '{1, 1, 1, 1, 1, 0, 0, 0}, 0, 8, 0, 0);    // 5
        send_char(5, '{8, 8, 8, 8, 8, 0, 0, 0}, 0, 8, 0, 0);    // 0
        send_char(5, '{2, 3, 3, 3, 3, 0, 0, 0}, 0, 8, 0, 0);    // 1 (boundary dot/dash)
        send_char(4, '{1, 1, 1, 1, 0, 0, 0, 0}, 0, 8, 0, 0);    // too short
        send_char(6, '{1, 1, 1, 1, 1, 1, 0, 0}, 0, 8, 0, 0);    // overflow
        send_char(5, '{1, 3, 1, 3, 1, 0, 0, 0}, 0, 8, 0, 0);    // not in table
        send_char(5, '{3, 1, 1, 1, 1, 0, 0, 0}, 0, 8, 1, 0);    // 3 clk, 2 ticks -> 5
        send_char(5, '{300, 1, 1, 1, 1, 0, 0, 0}, 0, 8, 0, 0);  // saturated dash -> 6
        send_char(5, '{1, 1, 1, 1, 1, 0, 0, 0}, 5, 8, 0, 0);    // 5-clk spaces -> 5

        // partial character aborted by reset
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        cyc(1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        last_digit = 4'd0;
        n_tests++;
        if (busy !== 1'b0 || digit !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_char: busy=%0b digit=%0d, required busy=0 digit=0", busy, digit);
        end
        repeat (3) cyc(1'b0, 1'b1);
        send_char(5, '{4, 1, 1, 1, 1, 0, 0, 0}, 0, 8, 0, 0);    // 6

        // press coinciding with gap completion starts the next character
        send_char(5, '{1, 1, 3, 3, 3, 0, 0, 0}, 2, 6, 0, 0);    // 2
        send_char(5, '{8, 8, 8, 8, 8, 0, 0, 0}, 2, 8, 0, 1);    // 0

        for (int c = 0; c < 40; c++) begin
            lens = '{0, 0, 0, 0, 0, 0, 0, 0};
            if ($urandom_range(0, 3) != 0) begin
                d = int'($urandom_range(0, 9));
                n = 5;
                for (int i = 0; i < 5; i++)
                    lens[i] = tbl[d][4-i] ? int'($urandom_range(1, DOT_MAX))
                                          : int'($urandom_range(DOT_MAX + 1, 10));
            end else begin
                n = int'($urandom_range(3, 7));
                for (int i = 0; i < n; i++)
                    lens[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, DOT_MAX))
                                                          : int'($urandom_range(DOT_MAX + 1, 10));
            end
            send_char(n, lens, 0, int'($urandom_range(8, 12)), 0, 0);
        end

        for (int i = 0; i < 100 && sbq.size() != 0; i++) cyc(1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: %0d outstanding, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
